// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_pkg
// Description : Shared types and helpers for the serial deserializer: FSM
//               state encoding and the frame-position counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package deser_pkg;

    // Framing state: waiting for the first ALIGN, or streaming words.
    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        RUN      = 1'b1
    } deser_state_t;

    // Counter width able to index OUTPUTS_NUM data bits plus a parity bit.
    function automatic int DESER_CNT_W(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/deser_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : deser_bit_counter
// Description : Frame-position counter. Loads 1 on (re)align, advances and
//               wraps to 0 after a programmable last index, clears
//               synchronously.
// Revision    : 1.0 - initial release
// ============================================================================
module deser_bit_counter
    import deser_pkg::*;
#(
    parameter int CNT_W = DESER_CNT_W(16)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load_one,
    input  logic             advance,
    input  logic [CNT_W-1:0] last_idx,
    output logic [CNT_W-1:0] cnt
);

    // Position of the next bit to be stored within the current frame.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (load_one) begin
            cnt <= CNT_W'(1);
        end else if (advance) begin
            cnt <= (cnt == last_idx) ? '0 : cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : serial_deserializer
// Description : Reassembles LSB-first serial words framed by an ALIGN strobe
//               on bit 0 and presents each completed word with a one-cycle
//               PAR_VALID pulse.
//               Optional macro DESER_PARITY_EN appends one even-parity bit to
//               every frame and reports the check on PARITY_ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int OUTPUTS_NUM = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   SERIAL_IN,
    input  logic                   ALIGN,
    output logic [OUTPUTS_NUM-1:0] PAR_OUT,
    output logic                   PAR_VALID,
    output logic                   LOCKED,
    output logic                   PARITY_ERR
);

    localparam int CNT_W = DESER_CNT_W(OUTPUTS_NUM);
`ifdef DESER_PARITY_EN
    localparam int LAST_IDX = OUTPUTS_NUM;
`else
    localparam int LAST_IDX = OUTPUTS_NUM - 1;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_IDX);

    deser_state_t           state;
    deser_state_t           state_next;
    logic [CNT_W-1:0]       cnt;
    logic [OUTPUTS_NUM-1:0] data_q;
    logic [OUTPUTS_NUM-1:0] data_next;
    logic [OUTPUTS_NUM-1:0] word_done;
    logic                   parity_calc;
    logic                   load_one;
    logic                   advance;
    logic                   complete;
    logic                   clear;

    deser_bit_counter #(
        .CNT_W(CNT_W)
    ) u_bit_counter (
        .clk      (CLK),
        .rst      (RESET),
        .clear    (clear),
        .load_one (load_one),
        .advance  (advance),
        .last_idx (LAST_CNT),
        .cnt      (cnt)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= UNLOCKED;
        end else begin
            state <= state_next;
        end
    end

    // Next state and counter controls. Any ALIGN restarts the frame at bit 0,
    // which covers both the normal cnt==0 case and every realign; a word is
    // only emitted when its final bit arrives without an ALIGN.
    always_comb begin
        state_next = state;
        load_one   = 1'b0;
        advance    = 1'b0;
        complete   = 1'b0;
        clear      = 1'b0;
        case (state)
            UNLOCKED: begin
                if (ALIGN) begin
                    load_one   = 1'b1;
                    state_next = RUN;
                end else begin
                    clear = 1'b1;
                end
            end
            RUN: begin
                if (ALIGN) begin
                    load_one = 1'b1;
                end else begin
                    advance  = 1'b1;
                    complete = (cnt == LAST_CNT);
                end
            end
            default: begin
                state_next = UNLOCKED;
            end
        endcase
    end

    // Data bit insertion at the current frame position; the parity position
    // lies beyond the data width and is never stored.
    always_comb begin
        data_next = data_q;
        if (load_one) begin
            data_next[0] = SERIAL_IN;
        end else if (advance) begin
            for (int i = 0; i < OUTPUTS_NUM; i++) begin
                if (cnt == CNT_W'(i)) begin
                    data_next[i] = SERIAL_IN;
                end
            end
        end
    end

`ifdef DESER_PARITY_EN
    // Final bit is the parity bit: the data word is already complete.
    assign word_done   = data_q;
    assign parity_calc = (^data_q) ^ SERIAL_IN;
`else
    // Final bit is the MSB of the data word.
    assign word_done   = data_next;
    assign parity_calc = 1'b0;
`endif

    // Assembly register and output word/strobes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q     <= '0;
            PAR_OUT    <= '0;
            PAR_VALID  <= 1'b0;
            PARITY_ERR <= 1'b0;
        end else begin
            data_q     <= data_next;
            PAR_VALID  <= complete;
            PARITY_ERR <= complete & parity_calc;
            if (complete) begin
                PAR_OUT <= word_done;
            end
        end
    end

    assign LOCKED = (state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_deserializer
// Description : Self-checking bench for serial_deserializer. A history-based
//               model derives every expected output from the input stream
//               since the last ALIGN; directed words pin known values.
//               Honours DESER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_deserializer;

    localparam int N = 16;
`ifdef DESER_PARITY_EN
    localparam int FRAME = N + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = N;
    localparam bit PAR   = 1'b0;
`endif
    localparam int HIST = 16384;

    logic         CLK       = 1'b0;
    logic         RESET     = 1'b1;
    logic         SERIAL_IN = 1'b0;
    logic         ALIGN     = 1'b0;
    logic [N-1:0] PAR_OUT;
    logic         PAR_VALID;
    logic         LOCKED;
    logic         PARITY_ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    serial_deserializer #(
        .OUTPUTS_NUM(N)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SERIAL_IN  (SERIAL_IN),
        .ALIGN      (ALIGN),
        .PAR_OUT    (PAR_OUT),
        .PAR_VALID  (PAR_VALID),
        .LOCKED     (LOCKED),
        .PARITY_ERR (PARITY_ERR)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A word is complete when the cycle lies FRAME-1 positions (mod FRAME)
    // after the most recent ALIGN since reset; its bits are simply the
    // recorded serial history of that frame.
    bit           hist [0:HIST-1];
    int           cyc        = 0;
    int           last_align = -1;
    logic [N-1:0] exp_out    = '0;
    logic         exp_valid  = 1'b0;
    logic         exp_perr   = 1'b0;
    logic         exp_locked = 1'b0;
    bit           started    = 1'b0;
    int           pulses     = 0;

    always @(posedge CLK) begin
        if (RESET) begin
            last_align = -1;
            exp_out    = '0;
            exp_valid  = 1'b0;
            exp_perr   = 1'b0;
            exp_locked = 1'b0;
            started    = 1'b1;
        end else begin
            if (cyc < HIST) hist[cyc] = SERIAL_IN;
            if (ALIGN) last_align = cyc;
            exp_locked = (last_align >= 0);
            exp_valid  = 1'b0;
            exp_perr   = 1'b0;
            if (last_align >= 0 && ((cyc - last_align) % FRAME) == FRAME - 1) begin
                exp_valid = 1'b1;
                for (int i = 0; i < N; i++) exp_out[i] = hist[cyc - FRAME + 1 + i];
                exp_perr = PAR ? ((^exp_out) ^ hist[cyc]) : 1'b0;
            end
        end
        cyc++;
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (started) begin
            check("par_valid", N'(PAR_VALID), N'(exp_valid));
            check("locked", N'(LOCKED), N'(exp_locked));
            check("parity_err", N'(PARITY_ERR), N'(exp_perr));
            check("par_out", PAR_OUT, exp_out);
            if (PAR_VALID === 1'b1) pulses++;
        end
    end

    // ---------------- directed stimulus helpers ----------------
    bit           pin_en   = 1'b0;
    logic [N-1:0] pin_val  = '0;
    logic         pin_perr = 1'b0;

    task automatic drive(input logic s, input logic a, input logic r);
        @(negedge CLK);
        SERIAL_IN = s;
        ALIGN     = a;
        RESET     = r;
    endtask

    // Checks the word expected to have completed on the previous edge.
    task automatic check_pin();
        if (pin_en) begin
            check("pin_valid", N'(PAR_VALID), N'(1));
            check("pin_word", PAR_OUT, pin_val);
            check("pin_perr", N'(PARITY_ERR), N'(pin_perr));
            pin_en = 1'b0;
        end
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit al, input bit pb);
        for (int i = 0; i < FRAME; i++) begin
            drive((i < N) ? w[i] : pb, al && (i == 0), 1'b0);
            if (i == 0) check_pin();
        end
        pin_en   = 1'b1;
        pin_val  = w;
        pin_perr = PAR ? ((^w) ^ pb) : 1'b0;
    endtask

    initial begin
        // Reset state.
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("reset_par_out", PAR_OUT, '0);
        check("reset_valid", N'(PAR_VALID), '0);
        check("reset_locked", N'(LOCKED), '0);
        check("reset_perr", N'(PARITY_ERR), '0);

        // No framing: toggling data, ALIGN held low.
        for (int i = 0; i < 40; i++) drive(logic'(i % 2), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("noframe_locked", N'(LOCKED), '0);
        check("noframe_pulses", N'(pulses), '0);

        // Basic word then a back-to-back word without ALIGN.
        send_word(16'hC5AF, 1'b1, ^16'hC5AF);
        send_word(16'h1234, 1'b0, ^16'h1234);
        drive(1'b0, 1'b0, 1'b0);
        check_pin();
        check("basic_locked", N'(LOCKED), N'(1));

        // Parity: correct even parity bit, then a wrong one.
        send_word(16'hC5AF, 1'b1, 1'b0);
        send_word(16'hC5AF, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check_pin();

        // Realign at bit 5 of a word.
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b0);
        send_word(16'hA55A, 1'b1, ^16'hA55A);
        drive(1'b0, 1'b0, 1'b0);
        check_pin();

        // Reset at bit 8, together with ALIGN (reset dominates).
        for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        check("midreset_par_out", PAR_OUT, '0);
        check("midreset_locked", N'(LOCKED), '0);
        check("midreset_valid", N'(PAR_VALID), '0);
        for (int i = 0; i < 20; i++) drive(logic'($urandom_range(0, 1)), 1'b0, 1'b0);
        send_word(16'h0F0F, 1'b1, ^16'h0F0F);
        drive(1'b0, 1'b0, 1'b0);
        check_pin();

        // Randomised stream with sporadic ALIGN and RESET.
        for (int i = 0; i < 4000; i++) begin
            drive(logic'($urandom_range(0, 1)),
                  logic'($urandom_range(0, 36) == 0),
                  logic'($urandom_range(0, 599) == 0));
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_deserializer.md
# serial_deserializer

Receive-side counterpart of the parallel-to-serial tree serializer: it samples one bit per clock on `SERIAL_IN` and reassembles words of `OUTPUTS_NUM` bits. Words are framed by an `ALIGN` strobe on bit 0. Each completed word is presented on `PAR_OUT` with a one-cycle `PAR_VALID` pulse. The block sits at the far end of the serial link and feeds downstream parallel logic.

## Interface
- `OUTPUTS_NUM`, default 16: data bits per word. Must be a power of two and ≥ 2. Must match the serializer's `INPUTS_NUM`.
- `CLK` in 1: single clock. All logic updates on the rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `SERIAL_IN` in 1: serial data, one bit per cycle, bit 0 of the word first.
- `ALIGN` in 1: high in the cycle in which `SERIAL_IN` carries bit 0 of a word.
- `PAR_OUT` out `OUTPUTS_NUM`: last completed word. Holds its value between completions.
- `PAR_VALID` out 1: one-cycle pulse marking that `PAR_OUT` was just updated.
- `LOCKED` out 1: high once framing has been acquired by `ALIGN`.
- `PARITY_ERR` out 1: parity check result, qualified by `PAR_VALID`. The port always exists; it is tied to 0 when parity is compiled out.

## Operation
- FSM states:
  - UNLOCKED (reset state): `SERIAL_IN` is ignored until `ALIGN` = 1. On an `ALIGN` cycle, that bit is stored as bit 0, the counter is set to 1, and the FSM moves to RUN with `LOCKED` = 1.
  - RUN: every cycle stores `SERIAL_IN` at index `cnt` and then increments `cnt`. The counter wraps after the last bit of the frame (index `OUTPUTS_NUM`−1, or `OUTPUTS_NUM` when parity is enabled) back to 0. Words stream back-to-back with no idle gap.
- Word completion: at the edge that samples the final frame bit, `PAR_OUT` is loaded with the assembled data, with the bit received at position i placed in `PAR_OUT[i]`. `PAR_VALID` is 1 for the following cycle only.
- `ALIGN` in RUN:
  - `ALIGN` = 1 with `cnt` = 0 is the normal case and has no extra effect.
  - `ALIGN` = 1 with `cnt` ≠ 0 is a realign. The partial word is discarded with no `PAR_VALID`. The current bit becomes bit 0 and `cnt` becomes 1. `LOCKED` stays 1.
  - `ALIGN` coinciding with the final bit of a frame (`cnt` = last index) is a realign: that word is discarded, not emitted.
- `LOCKED` only returns to 0 through `RESET`.

## Timing
- Reset values: `PAR_OUT` = 0, `PAR_VALID` = 0, `LOCKED` = 0, `PARITY_ERR` = 0. Internally, FSM = UNLOCKED and `cnt` = 0.
- `RESET` mid-word discards the partial word. No `PAR_VALID` is produced until a fresh `ALIGN`. `RESET` dominates a simultaneous `ALIGN`.
- Latency: `PAR_VALID` is high in the cycle immediately after the edge that samples the last frame bit. That is 1 cycle after the last data bit, or 1 cycle after the parity bit when parity is enabled.
- `PAR_VALID` period in steady state: `OUTPUTS_NUM` cycles, or `OUTPUTS_NUM`+1 with parity.
- `LOCKED` rises in the cycle after the edge that samples the first `ALIGN`.
- Counter width: `$clog2(OUTPUTS_NUM+1)` bits, sized for the parity case.

## Configuration
- Macro: `DESER_PARITY_EN`.
- Defined:
  - The frame is `OUTPUTS_NUM` data bits followed by one even-parity bit.
  - `PARITY_ERR` = XOR of all data bits and the parity bit. It is driven in the same cycle as `PAR_VALID` and is 0 in all other cycles.
  - A parity error does not suppress `PAR_VALID` or `PAR_OUT`.
- Undefined:
  - The frame is `OUTPUTS_NUM` bits.
  - `PARITY_ERR` is constant 0.

## Structure
- Package `deser_pkg`: FSM state enum (UNLOCKED, RUN) and a `DESER_CNT_W(n)` width function.
- One sub-module, `deser_bit_counter`: frame-position counter with load-to-1 on realign, wrap at a programmable last index, and synchronous clear.

## Test plan
- Basic word: `OUTPUTS_NUM` = 16. Send 16'b1100_0101_1010_1111 LSB-first with `ALIGN` on bit 0. Expect `PAR_OUT` = 16'hC5AF, `PAR_VALID` high for exactly one cycle after bit 15 is sampled, and `LOCKED` = 1.
- Back-to-back words: send 16'hC5AF then 16'h1234 with `ALIGN` only on the first bit 0. Expect two `PAR_VALID` pulses exactly 16 cycles apart carrying those values.
- Realign: assert `ALIGN` again at bit 5 of a word. Expect no pulse for the partial word and the next pulse 16 cycles after the realign, carrying the word started at the realign.
- Reset mid-word: assert `RESET` at bit 8. Expect all outputs 0 and `LOCKED` = 0, with no `PAR_VALID` until a new `ALIGN` plus 16 cycles.
- No framing: toggle `SERIAL_IN` for 40 cycles with `ALIGN` held 0. Expect `LOCKED` = 0 and `PAR_VALID` never asserted.
- Parity (`DESER_PARITY_EN` defined): send 16'hC5AF, which has ten 1s.
  - Parity bit 0: expect `PARITY_ERR` = 0.
  - Parity bit 1: expect `PARITY_ERR` = 1 together with `PAR_VALID`.
  - Expect a frame period of 17 cycles.
